// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared constants, FSM state type and width helper for the SAR serial receiver
package sar_pkg;

    localparam int BIT_ADC_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        SHIFT  = 2'd2
    } sar_state_t;

    // Enough bits to hold the values 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sar_rx_hold_reg.sv
// rtl/sar_rx_hold_reg.sv - valid/ready holding register with commit input and overrun pulse
module sar_rx_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         commit,
    input  logic [W-1:0] commit_data,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         overrun
);

    logic load;

    // A full register still takes a new word when the old one leaves this same cycle.
    assign load = commit && (!valid || ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= commit && valid && !ready;
            if (load) begin
                data  <= commit_data;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sar_serial_rx.sv
// rtl/sar_serial_rx.sv - SC-framed MSB-first serial word receiver; SAR_RX_CNT_EN adds SAMPLE_CNT
module sar_serial_rx
    import sar_pkg::*;
#(
    parameter int BIT_ADC = BIT_ADC_DEF
`ifdef SAR_RX_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               SC,
    input  logic               DIGITAL_OUT,
    output logic [BIT_ADC-1:0] DATA,
    output logic               DATA_VALID,
    input  logic               DATA_READY,
    output logic               BUSY,
    output logic               FRAME_ERR,
    output logic               OVERRUN
`ifdef SAR_RX_CNT_EN
    ,
    output logic [CNT_W-1:0]   SAMPLE_CNT
`endif
);

    localparam int CW = cnt_width(BIT_ADC);

    sar_state_t         state;
    logic [BIT_ADC-1:0] shift_reg;
    logic [CW-1:0]      bit_cnt;
    logic               commit;
    logic [BIT_ADC-1:0] commit_data;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            BUSY        <= 1'b0;
            FRAME_ERR   <= 1'b0;
            commit      <= 1'b0;
            commit_data <= '0;
        end else begin
            commit    <= 1'b0;
            FRAME_ERR <= 1'b0;
            case (state)
                IDLE: begin
                    if (SC) state <= SAMPLE;
                end
                SAMPLE: begin
                    if (!SC) begin
                        shift_reg <= BIT_ADC'(DIGITAL_OUT);
                        bit_cnt   <= CW'(1);
                        state     <= SHIFT;
                        BUSY      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (SC) begin
                        // Early SC: drop the partial word but honour the new sampling phase.
                        state     <= SAMPLE;
                        BUSY      <= 1'b0;
                        FRAME_ERR <= 1'b1;
                        bit_cnt   <= '0;
                    end else begin
                        shift_reg <= {shift_reg[BIT_ADC-2:0], DIGITAL_OUT};
                        if (bit_cnt == CW'(BIT_ADC - 1)) begin
                            commit      <= 1'b1;
                            commit_data <= {shift_reg[BIT_ADC-2:0], DIGITAL_OUT};
                            state       <= IDLE;
                            BUSY        <= 1'b0;
                            bit_cnt     <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    sar_rx_hold_reg #(
        .W(BIT_ADC)
    ) u_hold (
        .clk         (CLK),
        .rst         (RST),
        .commit      (commit),
        .commit_data (commit_data),
        .ready       (DATA_READY),
        .data        (DATA),
        .valid       (DATA_VALID),
        .overrun     (OVERRUN)
    );

`ifdef SAR_RX_CNT_EN
    logic word_loaded;

    assign word_loaded = commit && (!DATA_VALID || DATA_READY);

    always_ff @(posedge CLK) begin
        if (RST) SAMPLE_CNT <= '0;
        else if (word_loaded) SAMPLE_CNT <= SAMPLE_CNT + 1'b1;
    end
`endif

endmodule

// File: doc/sar_serial_rx.md
Name: sar_serial_rx

Overview:
- Receive side of the SAR ADC serial result interface: captures the MSB-first bit stream on DIGITAL_OUT, framed by SC, and rebuilds parallel BIT_ADC-bit conversion words.
- Sits downstream of the SAR logic, in the same CLK domain.
- Presents each word through a valid/ready holding register to the digital back end (FIFO, decimator, SPI readout).
- Flags malformed frames and words lost to back-pressure.

Parameters:
- BIT_ADC, 8, conversion resolution; number of serial bits per frame (legal 2..16).
- CNT_W, 16, width of SAMPLE_CNT; used only when SAR_RX_CNT_EN is defined.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  synchronous reset, active-high.
- SC  input  1  sample control from SAR logic; high = sampling phase, falling level starts the bit stream.
- DIGITAL_OUT  input  1  serial conversion bit from SAR logic, MSB first, one bit per CLK.
- DATA  output  BIT_ADC  last completed conversion word.
- DATA_VALID  output  1  DATA holds an unaccepted word.
- DATA_READY  input  1  consumer accepts DATA when DATA_VALID&&DATA_READY at a CLK edge.
- BUSY  output  1  frame in progress (state SHIFT).
- FRAME_ERR  output  1  one-cycle pulse: SC rose before all BIT_ADC bits were received.
- OVERRUN  output  1  one-cycle pulse: completed word dropped because the holding register was full.
- SAMPLE_CNT  output  CNT_W  delivered-word count; present only with SAR_RX_CNT_EN.

Behaviour:
- Reset: RST=1 sampled at a CLK edge forces the state to IDLE and clears the shift register, bit counter, DATA, DATA_VALID, BUSY, FRAME_ERR, OVERRUN and SAMPLE_CNT to 0. Reset mid-frame discards the partial word with no error pulse.
- IDLE: on SC=1, go to SAMPLE. DIGITAL_OUT is ignored.
- SAMPLE: hold while SC=1. On the first cycle with SC=0:
  - capture DIGITAL_OUT as the MSB;
  - set bit_cnt=1;
  - go to SHIFT.
- SHIFT, SC=0: shift DIGITAL_OUT in LSB-ward and increment bit_cnt. On the cycle that captures bit BIT_ADC-1 (the LSB):
  - commit the word;
  - go to IDLE.
- SHIFT, SC=1: abort the frame, pulse FRAME_ERR for 1 cycle, go to SAMPLE (the new sampling phase is honoured). No bit is captured that cycle.
- BUSY=1 exactly while the state is SHIFT.
- Commit latency: DATA and DATA_VALID update at the edge after the LSB capture edge, i.e. 1 cycle after the LSB was present on DIGITAL_OUT. Frame-to-output is BIT_ADC+1 cycles from the first SC=0 cycle.
- Holding register, commit cycle:
  - DATA_VALID=0: load DATA, set DATA_VALID=1.
  - DATA_VALID=1 and DATA_READY=1 in the same cycle: accept the old word, load the new one, DATA_VALID stays 1 (no bubble).
  - DATA_VALID=1 and DATA_READY=0: keep the old word, drop the new one, pulse OVERRUN.
- Holding register, non-commit cycle: DATA_VALID&&DATA_READY clears DATA_VALID. DATA is unchanged after accept.
- DATA is stable while DATA_VALID=1 and not yet accepted.
- Back-to-back frames: SC may rise in the same cycle as the commit; the FSM goes IDLE→SAMPLE next cycle. SC pulses of 1 cycle are legal.
- bit_cnt width is $clog2(BIT_ADC+1). There is no wrap inside a frame.

Optional Feature:
- Macro: SAR_RX_CNT_EN.
- Defined: SAMPLE_CNT port exists. It increments by 1 on every word loaded into the holding register (dropped words are not counted), wraps 2^CNT_W-1→0, and resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package sar_pkg:
  - BIT_ADC default constant;
  - FSM state enum (IDLE, SAMPLE, SHIFT) with 2-bit encoding;
  - bit_cnt width function.
- One natural sub-module, sar_rx_hold_reg: a BIT_ADC-wide valid/ready holding register with commit input and overrun pulse, reusable for parallel ADC outputs.
- FSM and shift register stay in the top.

Test Plan:
- RST for 2 cycles, then SC=1 for 3 cycles, then bits 1,0,1,0,0,1,0,1 with SC=0 and DATA_READY=1 → DATA=8'hA5, DATA_VALID=1 for 1 cycle, 9 cycles after the first SC=0 cycle; FRAME_ERR=0, OVERRUN=0.
- DATA_READY=0, two frames 8'hFF then 8'h00 → DATA stays 8'hFF with DATA_VALID held; OVERRUN pulses once at the second commit. Raise DATA_READY → DATA_VALID clears next edge.
- SC rises after 5 bits of a frame → FRAME_ERR one-cycle pulse, no DATA_VALID. The following full frame 8'h3C → DATA=8'h3C.
- DATA_VALID=1 with DATA_READY=1 exactly on the commit edge of frame 8'h81 → DATA=8'h81, DATA_VALID stays 1, no OVERRUN.
- RST asserted mid-frame after 4 bits → all outputs 0, state IDLE. Next full frame 8'h5A → DATA=8'h5A, no FRAME_ERR.
- With SAR_RX_CNT_EN, CNT_W=2: deliver 5 accepted frames → SAMPLE_CNT sequence 1,2,3,0,1. An overrun-dropped word does not increment it.
